wb_spi_mem: RTL
===============

Name: wb_spi_mem

Overview:
Wishbone responder (slave) for the OISC RISC-V core's data and instruction bus. Serves 32-bit reads and byte/half/word writes from an external SPI SRAM (23LC1024-class, 24-bit address, sequential mode) over single-bit SPI mode 0. It sits between the core's Wishbone initiator port and the chip pads.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles (>=1)
ADDR_BITS, 24, SPI address width sent after the opcode (multiple of 8)
CS_HIGH, 2, minimum clk cycles CS_n stays high between transactions (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_we_i  input  1  1 = write
wb_sel_i  input  4  byte enables, little-endian lanes
wb_adr_i  input  32  byte address; bits [ADDR_BITS-1:0] used
wb_dat_i  input  32  write data
wb_ack_o  output  1  one-cycle completion pulse
wb_dat_o  output  32  read data
spi_cs_n  output  1  chip select, active low
spi_sck  output  1  SPI clock
spi_mosi  output  1  serial data out
spi_miso  input  1  serial data in

Behaviour:
- Reset (reset low, async): spi_cs_n=1, spi_sck=0, spi_mosi=0, wb_ack_o=0, wb_dat_o=0, pending=0, FSM=IDLE (or INIT, see option). Asserting reset mid-transfer aborts immediately; no ack is issued.
- Request capture: the first clk edge with wb_cyc_i & wb_stb_i & !pending latches we, sel, adr and dat and sets pending. The initiator may drop stb/cyc after that one cycle. The responder always completes the transfer and pulses ack regardless of stb/cyc at completion. Strobes while pending=1 are ignored.
- FSM: IDLE -> CMD (8 bits) -> ADDR (ADDR_BITS) -> DATA (8*n bits) -> GAP (CS_HIGH cycles) -> IDLE.
  - CS_n falls 1 cycle after capture.
  - On the last SCK falling edge of DATA: CS_n rises and wb_ack_o pulses for exactly 1 cycle.
  - pending clears on the ack cycle.
- SPI mode 0:
  - SCK idles low.
  - MOSI is set up while SCK is low and is stable for CLK_DIV cycles before the rising edge.
  - MISO is sampled on the SCK rising edge.
  - Each bit takes 2*CLK_DIV clk cycles. Bits go out MSB first.
- Read (we=0): opcode 0x03, address = {adr[ADDR_BITS-1:2],2'b00}, 4 data bytes.
  - The first byte received maps to wb_dat_o[7:0], the last to [31:24].
  - sel and adr[1:0] are ignored; the initiator aligns the data.
  - wb_dat_o updates on the ack cycle and holds until the next read ack.
- Write (we=1): opcode 0x02.
  - lo = lowest set bit of sel, hi = highest set bit of sel.
  - Address = {adr[ADDR_BITS-1:2],lo[1:0]}.
  - Bytes lo..hi of wb_dat_i are sent in ascending order, n = hi-lo+1.
  - sel must be contiguous. A non-contiguous sel writes the full lo..hi span (unsupported; not checked).
  - sel=0 acks after the command and address phases with no data bytes.
- Latency, capture edge to ack: 1 + 2*CLK_DIV*(8+ADDR_BITS+8n) cycles.
  - Read, CLK_DIV=2: 257.
  - Byte write: 161.
- CLK_DIV counter and bit counter wrap only at phase boundaries. No SCK edge is emitted while CS_n is high.

Optional Feature:
SPI_MEM_MODE_INIT_EN
- Defined: after reset the FSM starts in INIT and sends the mode-register write 0x01, 0x40 (sequential mode) as one 16-bit CS-framed transfer, followed by GAP, then IDLE.
  - A request captured during INIT stays pending and is served after GAP.
  - No ack is issued for INIT.
- Undefined: the FSM starts in IDLE and INIT logic is absent. Sequential mode is assumed to be the SRAM default.

Decomposition:
- Shared package wb_spi_mem_pkg:
  - opcodes OP_READ=8'h03, OP_WRITE=8'h02, OP_WRMR=8'h01, MODE_SEQ=8'h40
  - one-hot FSM state bit indices
- Sub-module spi_shift_engine: SCK divider plus a 32-bit shift register.
  - Interface: start, nbits, tx word; done pulse, rx word.
  - The FSM reuses it for CMD, ADDR and DATA phases.

Test Plan:
- Word read, CLK_DIV=2, SRAM model holds 0x11,0x22,0x33,0x44 at 0x000100 -> MOSI shows 0x03,0x000100; wb_dat_o=0x44332211; ack 257 cycles after capture, 1 cycle wide.
- Byte write sel=4'b0100, adr=0x00000202, dat=0xAABBCCDD -> MOSI 0x02,0x000202,0xBB; 40 SCK pulses; model byte 0x202=0xBB; neighbours unchanged.
- Half write sel=4'b1100, adr=0x10, dat=0x1234ABCD -> address 0x000012, bytes 0x34,0x12; read-back of word 0x10 gives 0x1234xxxx.
- Single-cycle stb (dropped after capture), plus a second stb while busy -> exactly one transfer, one ack; second strobe ignored.
- reset low asserted mid-ADDR -> CS_n=1 and SCK=0 asynchronously; no ack; the next request after release completes normally.
- SPI_MEM_MODE_INIT_EN defined -> first CS frame after reset carries 0x01,0x40; a read strobed during INIT is served after GAP with the correct data.

Source files
------------

// File: rtl/wb_spi_mem_pkg.sv
// Shared definitions for the Wishbone-to-SPI-SRAM responder: SPI opcodes,
// one-hot FSM state encoding and small lane/byte helpers.
package wb_spi_mem_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WRMR  = 8'h01;
    localparam logic [7:0] MODE_SEQ = 8'h40;

    localparam int S_IDLE     = 0;
    localparam int S_CMD      = 1;
    localparam int S_ADDR     = 2;
    localparam int S_DATA     = 3;
    localparam int S_GAP      = 4;
    localparam int S_INIT     = 5;
    localparam int NUM_STATES = 6;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE = 6'(1 << S_IDLE),
        ST_CMD  = 6'(1 << S_CMD),
        ST_ADDR = 6'(1 << S_ADDR),
        ST_DATA = 6'(1 << S_DATA),
        ST_GAP  = 6'(1 << S_GAP),
        ST_INIT = 6'(1 << S_INIT)
    } state_e;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // An empty select reports lane 0 for both ends.
    function automatic logic [1:0] lowest_lane(input logic [3:0] sel);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (sel[i]) lane = 2'(i);
        return lane;
    endfunction

    function automatic logic [1:0] highest_lane(input logic [3:0] sel);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = 0; i < 4; i++)
            if (sel[i]) lane = 2'(i);
        return lane;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCK divider plus 32-bit MSB-first shifter. done is
// asserted combinationally on the edge that produces the final SCK fall, so a
// new start on that same edge chains phases with no idle SCK cycle.
module spi_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] tx,
    output logic        done,
    output logic        busy,
    output logic [31:0] rx,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   sh;
    logic          half_end;

    assign half_end = busy && (div_cnt == DW'(CLK_DIV - 1));
    assign done     = half_end && sck && (bit_cnt == 5'd0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees pre-edge values and block order cannot matter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            rx      <= '0;
        end else if (start && (!busy || done)) begin
            busy    <= 1'b1;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 5'(nbits - 6'd1);
            mosi    <= tx[31];
            sh      <= {tx[30:0], 1'b0};
        end else if (busy) begin
            if (!half_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                    rx  <= {rx[30:0], miso};
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 5'd0) begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                        mosi    <= sh[31];
                        sh      <= {sh[30:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_spi_mem.sv
// Wishbone responder serving word reads and byte/half/word writes from a
// 23LC1024-class SPI SRAM. Define SPI_MEM_MODE_INIT_EN to send the
// sequential-mode register write after every reset.
module wb_spi_mem
    import wb_spi_mem_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_BITS = 24,
    parameter int CS_HIGH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int GW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

    state_e         state;
    logic           pending, we_q;
    logic [3:0]     sel_q;
    logic [31:0]    adr_q, dat_q;
    logic [GW-1:0]  gap_cnt;

    logic           req_fire;
    logic [1:0]     lo, hi;
    logic [2:0]     nbytes;
    logic [ADDR_BITS-1:0] spi_addr;
    logic [31:0]    addr_word, data_word;
    logic [7:0]     opcode;

    logic           eng_start, eng_done, eng_busy;
    logic [5:0]     eng_nbits;
    logic [31:0]    eng_tx, eng_rx;
    logic           unused_adr;

    assign req_fire  = wb_cyc_i && wb_stb_i && !pending;
    assign lo        = lowest_lane(sel_q);
    assign hi        = highest_lane(sel_q);
    assign nbytes    = !we_q ? 3'd4 : (sel_q == 4'd0) ? 3'd0 : 3'(hi) - 3'(lo) + 3'd1;
    assign spi_addr  = {adr_q[ADDR_BITS-1:2], we_q ? lo : 2'b00};
    assign addr_word = 32'(spi_addr) << (32 - ADDR_BITS);
    // Lane lo moves to the top byte so the lowest lane is shifted out first.
    assign data_word = we_q ? byte_swap(dat_q >> {lo, 3'b000}) : 32'h0;
    assign opcode    = we_q ? OP_WRITE : OP_READ;
    assign unused_adr = ^(adr_q >> ADDR_BITS);

    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        eng_start = 1'b0;
        eng_nbits = 6'd8;
        eng_tx    = {opcode, 24'h0};
        case (state)
            ST_CMD: begin
                if (!eng_busy) begin
                    eng_start = 1'b1;
                end else if (eng_done) begin
                    eng_start = 1'b1;
                    eng_nbits = 6'(ADDR_BITS);
                    eng_tx    = addr_word;
                end
            end
            ST_ADDR: begin
                if (eng_done && nbytes != 3'd0) begin
                    eng_start = 1'b1;
                    eng_nbits = {nbytes, 3'b000};
                    eng_tx    = data_word;
                end
            end
`ifdef SPI_MEM_MODE_INIT_EN
            ST_INIT: begin
                if (!eng_busy) begin
                    eng_start = 1'b1;
                    eng_nbits = 6'd16;
                    eng_tx    = {OP_WRMR, MODE_SEQ, 16'h0};
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef SPI_MEM_MODE_INIT_EN
            state <= ST_INIT;
`else
            state <= ST_IDLE;
`endif
            pending  <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            gap_cnt  <= '0;
            spi_cs_n <= 1'b1;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            if (req_fire) begin
                pending <= 1'b1;
                we_q    <= wb_we_i;
                sel_q   <= wb_sel_i;
                adr_q   <= wb_adr_i;
                dat_q   <= wb_dat_i;
            end
            case (state)
                ST_IDLE: if (pending || req_fire) state <= ST_CMD;
                ST_CMD: begin
                    if (!eng_busy)     spi_cs_n <= 1'b0;
                    else if (eng_done) state    <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (eng_done) begin
                        if (nbytes != 3'd0) begin
                            state <= ST_DATA;
                        end else begin
                            spi_cs_n <= 1'b1;
                            wb_ack_o <= 1'b1;
                            pending  <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= ST_GAP;
                        end
                    end
                end
                ST_DATA: begin
                    if (eng_done) begin
                        if (!we_q) wb_dat_o <= byte_swap(eng_rx);
                        spi_cs_n <= 1'b1;
                        wb_ack_o <= 1'b1;
                        pending  <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(CS_HIGH - 1)) state <= ST_IDLE;
                    else                              gap_cnt <= gap_cnt + 1'b1;
                end
`ifdef SPI_MEM_MODE_INIT_EN
                ST_INIT: begin
                    if (!eng_busy) begin
                        spi_cs_n <= 1'b0;
                    end else if (eng_done) begin
                        spi_cs_n <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .nbits (eng_nbits),
        .tx    (eng_tx),
        .done  (eng_done),
        .busy  (eng_busy),
        .rx    (eng_rx),
        .sck   (spi_sck),
        .mosi  (spi_mosi),
        .miso  (spi_miso)
    );

endmodule
